// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and the width ceiling.
package serial_adder_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, shared bit-serially by serial_adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake at this level.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell walks a WIDTH-bit operand pair LSB first; SERIAL_ADDER_OVF_EN adds signed ovf.
// Latency: WIDTH cycles from the accept edge to out_valid; one op per WIDTH+2 cycles at best.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             c_msb;
`endif

    full_adder FA0 (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_nxt = fa_s;
        end else begin : g_wn
            assign sum_nxt = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            c_msb   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry   <= cin;
                        bit_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= sum_nxt;
                    carry   <= fa_co;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (last_bit) begin
`ifdef SERIAL_ADDER_OVF_EN
                        c_msb <= carry;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_sh;
    assign cout      = carry;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = c_msb ^ carry;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 1 and 16 against an arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        i8_valid, i8_ready, o8_valid, o8_ready, cin8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        i1_valid, i1_ready, o1_valid, o1_ready, cin1, cout1;
    logic [0:0]  a1, b1, sum1;
    logic        i16_valid, i16_ready, o16_valid, o16_ready, cin16, cout16;
    logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf8, ovf1, ovf16;
`endif

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(i8_valid), .in_ready(i8_ready),
        .a(a8), .b(b8), .cin(cin8), .out_valid(o8_valid), .out_ready(o8_ready),
        .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(i1_valid), .in_ready(i1_ready),
        .a(a1), .b(b1), .cin(cin1), .out_valid(o1_valid), .out_ready(o1_ready),
        .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(i16_valid), .in_ready(i16_ready),
        .a(a16), .b(b16), .cin(cin16), .out_valid(o16_valid), .out_ready(o16_ready),
        .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf16)
`endif
    );

    // Submit one operation to the WIDTH=8 instance; returns at the first falling edge with out_valid high.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co, output int lat);
        int g;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; i8_valid = 1'b1;
        g = 0;
        while (!i8_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        i8_valid = 1'b0;
        lat = 0;
        while (!o8_valid && lat < 200) begin @(posedge clk); lat++; @(negedge clk); end
        s = sum8; co = cout8;
    endtask

    task automatic run1(input logic a, input logic b, input logic c,
                        output logic s, output logic co, output int lat);
        int g;
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; i1_valid = 1'b1;
        g = 0;
        while (!i1_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        i1_valid = 1'b0;
        lat = 0;
        while (!o1_valid && lat < 200) begin @(posedge clk); lat++; @(negedge clk); end
        s = sum1[0]; co = cout1;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output logic [15:0] s, output logic co, output int lat);
        int g;
        @(negedge clk);
        a16 = a; b16 = b; cin16 = c; i16_valid = 1'b1;
        g = 0;
        while (!i16_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        i16_valid = 1'b0;
        lat = 0;
        while (!o16_valid && lat < 200) begin @(posedge clk); lat++; @(negedge clk); end
        s = sum16; co = cout16;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({i8_ready, o8_valid, sum8, cout8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_w8: got rdy=%b vld=%b sum=%h cout=%b, want 1 0 00 0", i8_ready, o8_valid, sum8, cout8);
        end
        n_checks++;
        if ({i1_ready, o1_valid, i16_ready, o16_valid} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_w1_w16: got %b%b%b%b, want 1010", i1_ready, o1_valid, i16_ready, o16_valid);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf8 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf8); end
`endif
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({i8_ready, o8_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_idle: got rdy=%b vld=%b want 1 0", i8_ready, o8_valid);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co; int lat;
        o8_ready = 1'b1;
        run8(8'd100, 8'd27, 1'b0, s, co, lat);
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
        n_checks++;
        if ({co, s} !== 9'd127) begin n_fail++; $display("FAIL basic_sum: got cout=%b sum=%0d want 0 127", co, s); end
        n_checks++;
        if (i8_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy: in_ready=%b want 0", i8_ready); end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({i8_ready, o8_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_return_idle: got rdy=%b vld=%b want 1 0", i8_ready, o8_valid);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] s; logic co; int lat;
        o8_ready = 1'b1;
        run8(8'hFF, 8'h01, 1'b0, s, co, lat);
        n_checks++;
        if ({co, s} !== 9'h100) begin n_fail++; $display("FAIL wrap_ff_01: got cout=%b sum=%h want 1 00", co, s); end
        run8(8'hFF, 8'hFF, 1'b1, s, co, lat);
        n_checks++;
        if ({co, s} !== 9'h1FF) begin n_fail++; $display("FAIL wrap_ff_ff_1: got cout=%b sum=%h want 1 ff", co, s); end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [7:0] s; logic co; int lat;
        o8_ready = 1'b1;
        run8(8'h7F, 8'h01, 1'b0, s, co, lat);
        n_checks++;
        if ({ovf8, co, s} !== {1'b1, 1'b0, 8'h80}) begin
            n_fail++; $display("FAIL ovf_7f_01: got ovf=%b cout=%b sum=%h want 1 0 80", ovf8, co, s);
        end
        run8(8'h80, 8'hFF, 1'b0, s, co, lat);
        n_checks++;
        if ({ovf8, co, s} !== {1'b1, 1'b1, 8'h7F}) begin
            n_fail++; $display("FAIL ovf_80_ff: got ovf=%b cout=%b sum=%h want 1 1 7f", ovf8, co, s);
        end
        run8(8'h05, 8'hFE, 1'b0, s, co, lat);
        n_checks++;
        if ({ovf8, co, s} !== {1'b0, 1'b1, 8'h03}) begin
            n_fail++; $display("FAIL ovf_05_fe: got ovf=%b cout=%b sum=%h want 0 1 03", ovf8, co, s);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int t1, t2, g;
        o8_ready = 1'b1;
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd2; cin8 = 1'b0; i8_valid = 1'b1;
        g = 0;
        while (!o8_valid && g < 50) begin @(negedge clk); g++; end
        t1 = cyc;
        g = 0;
        while (o8_valid && g < 50) begin @(negedge clk); g++; end
        g = 0;
        while (!o8_valid && g < 50) begin @(negedge clk); g++; end
        t2 = cyc;
        i8_valid = 1'b0;
        n_checks++;
        if (t2 - t1 !== 10) begin n_fail++; $display("FAIL b2b_period: got %0d cycles want 10", t2 - t1); end
        n_checks++;
        if (sum8 !== 8'd3) begin n_fail++; $display("FAIL b2b_sum: got %0d want 3", sum8); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] s; logic co; int lat;
        o8_ready = 1'b0;
        run8(8'h12, 8'h34, 1'b1, s, co, lat);
        n_checks++;
        if ({co, s} !== 9'h047) begin n_fail++; $display("FAIL bp_sum: got cout=%b sum=%h want 0 47", co, s); end
        for (int i = 0; i < 5; i++) begin
            i8_valid = ~i8_valid;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({o8_valid, i8_ready, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 8'h47}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b cout=%b sum=%h want 1 0 0 47", i, o8_valid, i8_ready, cout8, sum8);
            end
        end
        i8_valid = 1'b0;
        o8_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({o8_valid, i8_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", o8_valid, i8_ready);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({o8_valid, i8_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_single_handshake: got vld=%b rdy=%b want 0 1", o8_valid, i8_ready);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] s; logic co; int lat; int g;
        o8_ready = 1'b1;
        @(negedge clk);
        a8 = 8'h06; b8 = 8'h07; cin8 = 1'b0; i8_valid = 1'b1;
        g = 0;
        while (!i8_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        #1 i8_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({i8_ready, o8_valid, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b vld=%b cout=%b sum=%h want 1 0 0 00", i8_ready, o8_valid, cout8, sum8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'd3, 8'd4, 1'b0, s, co, lat);
        n_checks++;
        if ({co, s, lat} !== {1'b0, 8'd7, 32'd8}) begin
            n_fail++; $display("FAIL post_reset_op: got cout=%b sum=%0d lat=%0d want 0 7 8", co, s, lat);
        end
    endtask

    task automatic test_width1();
        logic s, co; int lat; logic a, b, c; logic [1:0] e;
        o1_ready = 1'b1;
        run1(1'b1, 1'b1, 1'b1, s, co, lat);
        n_checks++;
        if ({co, s, lat} !== {1'b1, 1'b1, 32'd1}) begin
            n_fail++; $display("FAIL w1_111: got cout=%b sum=%b lat=%0d want 1 1 1", co, s, lat);
        end
        for (int i = 0; i < 16; i++) begin
            a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
            e = 2'(a) + 2'(b) + 2'(c);
            run1(a, b, c, s, co, lat);
            n_checks++;
            if ({co, s} !== e || lat !== 1) begin
                n_fail++; $display("FAIL w1_rand[%0d]: got cout=%b sum=%b lat=%0d want %b lat 1", i, co, s, lat, e);
            end
        end
    endtask

    task automatic test_random16();
        logic [15:0] a, b, s; logic c, co; int lat;
        longint unsigned e;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
            if (i % 7 == 0) a = 16'hFFFF;
            o16_ready = 1'b0;
            e = longint'(a) + longint'(b) + longint'(c);
            run16(a, b, c, s, co, lat);
            n_checks++;
            if ({co, s} !== e[16:0] || lat !== 16) begin
                n_fail++;
                $display("FAIL w16_rand[%0d]: %h+%h+%b got cout=%b sum=%h lat=%0d want %h lat 16", i, a, b, c, co, s, lat, e[16:0]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            n_checks++;
            if (ovf16 !== ((a[15] == b[15]) && (s[15] != a[15]))) begin
                n_fail++; $display("FAIL w16_ovf[%0d]: got %b for %h+%h", i, ovf16, a, b);
            end
`endif
            repeat ($urandom_range(0, 2)) @(negedge clk);
            o16_ready = 1'b1;
            @(posedge clk); #1 o16_ready = 1'b0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        {i8_valid, o8_ready, cin8, a8, b8} = '0;
        {i1_valid, o1_ready, cin1, a1, b1} = '0;
        {i16_valid, o16_ready, cin16, a16, b16} = '0;
        test_reset();
        test_basic();
        test_wrap();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_width1();
        test_random16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
